result_uart_dump: RTL and testbench

RESULT_UART_DUMP -- requirements
Module: result_uart_dump

---
 rtl/result_uart_dump_pkg.sv | 18 +
 rtl/result_uart_dump_byte_serializer.sv | 42 ++++
 rtl/result_uart_dump.sv | 208 ++++++++++++++++++++
 tb/tb_result_uart_dump.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_uart_dump_pkg.sv
// Shared definitions for the result RAM UART dump block.
package result_uart_dump_pkg;

    localparam int unsigned N_DFLT        = 2;
    localparam logic [7:0]  HDR_BYTE_DFLT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        RD_WAIT,
        SEND,
        WAIT_TX,
        CSUM,
        FIN
    } state_t;

endpackage

// File: rtl/result_uart_dump_byte_serializer.sv
// Holds one 32-bit result word and presents it a byte at a time, MSB first.
module byte_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        shift,
    input  logic [31:0] data_in,
    output logic [7:0]  byte_out,
    output logic        last_byte
);

    logic [31:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;

    // Next-state: a load restarts the word, a shift advances to the next byte.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = data_in;
            cnt_d = 2'd0;
        end else if (shift) begin
            sr_d  = {sr_q[23:0], 8'h00};
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Register the shift state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign byte_out  = sr_q[31:24];
    assign last_byte = (cnt_q == 2'd3);

endmodule

// File: rtl/result_uart_dump.sv
// Dumps the N*N result RAMs over the UART as one framed, XOR-checksummed stream.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start
// HDR     | issue header byte
// RD      | one-cycle read enable of the current RAM at addr_q
// RD_WAIT | count down RAM read latency, load serializer on the last cycle
// SEND    | issue the serializer's current byte
// WAIT_TX | wait for the UART to finish the outstanding byte
// CSUM    | issue the checksum byte
// FIN     | done pulse, busy drops
module result_uart_dump
    import result_uart_dump_pkg::*;
#(
    parameter int         N        = N_DFLT,
    parameter int         ADDR_W   = 11,
    parameter int         RD_LAT   = 2,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     word_cnt,
    output logic [ADDR_W-1:0]     ram_c_addr,
    output logic [N*N-1:0]        ram_c_rden,
    input  logic [N*N*32-1:0]     ram_c_q,
    output logic [7:0]            uart_tx_data,
    output logic                  uart_send_data,
    input  logic                  uart_tx_done,
    output logic                  busy,
    output logic                  done
);

    localparam int NN    = N * N;
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                send_q, send_d;
    logic [NN-1:0]       rden_q, rden_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                in_data_q, in_data_d;
    logic                csum_sent_q, csum_sent_d;

    logic                ser_load;
    logic                ser_shift;
    logic [7:0]          ser_byte;
    logic                ser_last;
    logic [31:0]         ram_word;
    logic                last_word;

    assign ram_word  = ram_c_q[32*int'(idx_q) +: 32];
    assign last_word = (idx_q == IDX_W'(NN - 1)) && (addr_q == (wcnt_q - ADDR_W'(1)));
    assign ser_load  = (state_q == RD_WAIT) && (lat_q == '0);
    assign ser_shift = (state_q == WAIT_TX) && uart_tx_done && in_data_q && !csum_sent_q && !ser_last;

    byte_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .shift     (ser_shift),
        .data_in   (ram_word),
        .byte_out  (ser_byte),
        .last_byte (ser_last)
    );

    // Frame sequencing; every output is computed one cycle ahead and registered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        csum_d      = csum_q;
        tx_data_d   = tx_data_q;
        send_d      = 1'b0;
        rden_d      = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_data_d   = in_data_q;
        csum_sent_d = csum_sent_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    wcnt_d      = word_cnt;
                    addr_d      = '0;
                    idx_d       = '0;
                    csum_d      = '0;
                    in_data_d   = 1'b0;
                    csum_sent_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = HDR;
                end
            end
            HDR: begin
                tx_data_d = HDR_BYTE;
                send_d    = 1'b1;
                csum_d    = csum_q ^ HDR_BYTE;
                state_d   = WAIT_TX;
            end
            RD: begin
                lat_d   = LAT_W'(RD_LAT - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_q == '0) begin
                    state_d = SEND;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            SEND: begin
                tx_data_d = ser_byte;
                send_d    = 1'b1;
                csum_d    = csum_q ^ ser_byte;
                in_data_d = 1'b1;
                state_d   = WAIT_TX;
            end
            WAIT_TX: begin
                if (uart_tx_done) begin
                    if (csum_sent_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else if (in_data_q && !ser_last) begin
                        state_d = SEND;
                    end else if ((!in_data_q && wcnt_q == '0) || (in_data_q && last_word)) begin
                        state_d = CSUM;
                    end else begin
                        // Header just finished: addr/idx already point at the first word.
                        if (in_data_q) begin
                            if (idx_q == IDX_W'(NN - 1)) begin
                                idx_d  = '0;
                                addr_d = addr_q + ADDR_W'(1);
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                        rden_d[idx_d] = 1'b1;
                        state_d       = RD;
                    end
                end
            end
            CSUM: begin
                tx_data_d   = csum_q;
                send_d      = 1'b1;
                csum_sent_d = 1'b1;
                state_d     = WAIT_TX;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wcnt_q      <= '0;
            idx_q       <= '0;
            lat_q       <= '0;
            csum_q      <= '0;
            tx_data_q   <= '0;
            send_q      <= 1'b0;
            rden_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_data_q   <= 1'b0;
            csum_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            csum_q      <= csum_d;
            tx_data_q   <= tx_data_d;
            send_q      <= send_d;
            rden_q      <= rden_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_data_q   <= in_data_d;
            csum_sent_q <= csum_sent_d;
        end
    end

    assign ram_c_addr     = addr_q;
    assign ram_c_rden     = rden_q;
    assign uart_tx_data   = tx_data_q;
    assign uart_send_data = send_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_result_uart_dump.sv
// Directed bench for result_uart_dump: one RD_LAT=2 instance, one RD_LAT=1 instance.
module tb_result_uart_dump;

    localparam int AW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          start0, start1;
    logic [AW-1:0] wc0, wc1;
    logic [AW-1:0] addr0, addr1;
    logic [3:0]    rden0, rden1;
    logic [127:0]  q0, q1;
    logic [7:0]    txd0, txd1;
    logic          send0, send1;
    logic          txdone0, txdone1;
    logic          busy0, busy1;
    logic          done0, done1;

    result_uart_dump #(.N(2), .ADDR_W(AW), .RD_LAT(2), .HDR_BYTE(8'hA5)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .word_cnt(wc0),
        .ram_c_addr(addr0), .ram_c_rden(rden0), .ram_c_q(q0),
        .uart_tx_data(txd0), .uart_send_data(send0), .uart_tx_done(txdone0),
        .busy(busy0), .done(done0));

    result_uart_dump #(.N(2), .ADDR_W(AW), .RD_LAT(1), .HDR_BYTE(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .word_cnt(wc1),
        .ram_c_addr(addr1), .ram_c_rden(rden1), .ram_c_q(q1),
        .uart_tx_data(txd1), .uart_send_data(send1), .uart_tx_done(txdone1),
        .busy(busy1), .done(done1));

    // RAM models: only the enabled RAM returns data, others return a poison word.
    logic [31:0]  mem0 [0:3][0:7];
    logic [31:0]  mem1 [0:3][0:7];
    logic [127:0] st0;

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            st0[k*32 +: 32] <= rden0[k] ? mem0[k][addr0[2:0]] : 32'hDEADBEEF;
            q1[k*32 +: 32]  <= rden1[k] ? mem1[k][addr1[2:0]] : 32'hDEADBEEF;
        end
        q0 <= st0;
    end

    // UART models: tx_done 10 cycles after each send; overlapping sends are counted.
    int   pend0 = 0, pend1 = 0;
    int   overlap0 = 0, overlap1 = 0;
    logic mdone0 = 1'b0, mdone1 = 1'b0;
    logic spur0;
    assign txdone0 = mdone0 | spur0;
    assign txdone1 = mdone1;

    always @(posedge clk) begin
        mdone0 <= 1'b0;
        if (rst) begin
            pend0 <= 0;
        end else if (send0) begin
            if (pend0 != 0) overlap0 <= overlap0 + 1;
            pend0 <= 10;
        end else if (pend0 != 0) begin
            if (pend0 == 1) mdone0 <= 1'b1;
            pend0 <= pend0 - 1;
        end
    end

    always @(posedge clk) begin
        mdone1 <= 1'b0;
        if (rst) begin
            pend1 <= 0;
        end else if (send1) begin
            if (pend1 != 0) overlap1 <= overlap1 + 1;
            pend1 <= 10;
        end else if (pend1 != 0) begin
            if (pend1 == 1) mdone1 <= 1'b1;
            pend1 <= pend1 - 1;
        end
    end

    // Output monitors, sampled on the falling edge.
    logic [7:0]    bytes0[$], bytes1[$];
    logic [3:0]    rlog0[$];
    logic [AW-1:0] alog0[$];
    int sends0 = 0, dones0 = 0, dones1 = 0, onehot_bad0 = 0, busy_done_bad = 0;

    always @(negedge clk) begin
        if (send0) begin bytes0.push_back(txd0); sends0 = sends0 + 1; end
        if (send1) bytes1.push_back(txd1);
        if (done0) dones0 = dones0 + 1;
        if (done1) dones1 = dones1 + 1;
        if ((done0 && busy0) || (done1 && busy1)) busy_done_bad = busy_done_bad + 1;
        if (rden0 != 4'd0) begin
            rlog0.push_back(rden0);
            alog0.push_back(addr0);
            if ($countones(rden0) != 1) onehot_bad0 = onehot_bad0 + 1;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input int inst, input int wc);
        if (inst == 0) begin start0 = 1'b1; wc0 = AW'(wc); end
        else begin start1 = 1'b1; wc1 = AW'(wc); end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int base, input string tag);
        int n;
        n = 0;
        while (((inst == 0) ? dones0 : dones1) == base && n < 5000) begin
            tick();
            n++;
        end
        repeat (30) tick();
        chk({tag, "_done_cnt"}, (inst == 0) ? dones0 : dones1, base + 1);
        chk({tag, "_busy_low"}, (inst == 0) ? busy0 : busy1, 1'b0);
    endtask

    task automatic check_frame(input int inst, input int base, input logic [7:0] exp[$], input string tag);
        int n;
        n = ((inst == 0) ? bytes0.size() : bytes1.size()) - base;
        chk({tag, "_len"}, n, exp.size());
        for (int i = 0; i < exp.size() && i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), (inst == 0) ? bytes0[base+i] : bytes1[base+i], exp[i]);
    endtask

    logic [7:0] e[$];
    logic [7:0] cs;
    int b0, d0, r0, s5;

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        wc0    = '0;
        wc1    = '0;
        spur0  = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 8; a++) begin
                mem0[k][a] = 32'h0;
                mem1[k][a] = 32'h0;
            end
        repeat (3) tick();
        chk("rst_send", send0, 1'b0);
        chk("rst_rden", rden0, 4'h0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_addr", addr0, 0);
        chk("rst_txdata", txd0, 8'h00);
        rst = 1'b0;
        tick();

        // Scenario: one word per RAM, hand-listed bytes.
        mem0[0][0] = 32'h11223344;
        mem0[1][0] = 32'h55667788;
        mem0[2][0] = 32'h99AABBCC;
        mem0[3][0] = 32'hDDEEFF00;
        e = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'hA5};
        b0 = bytes0.size(); d0 = dones0;
        start_frame(0, 1);
        chk("s1_busy_high", busy0, 1'b1);
        wait_done(0, d0, "s1");
        check_frame(0, b0, e, "s1");

        // Scenario: empty frame.
        b0 = bytes0.size(); d0 = dones0; r0 = rlog0.size();
        start_frame(0, 0);
        wait_done(0, d0, "s2");
        e = '{8'hA5, 8'hA5};
        check_frame(0, b0, e, "s2");
        chk("s2_no_rden", rlog0.size() - r0, 0);

        // Scenario: three words, data equals address.
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 8; a++) mem0[k][a] = 32'(a);
        b0 = bytes0.size(); d0 = dones0; r0 = rlog0.size();
        start_frame(0, 3);
        wait_done(0, d0, "s3");
        e = {};
        e.push_back(8'hA5);
        for (int a = 0; a < 3; a++)
            for (int k = 0; k < 4; k++) begin
                e.push_back(8'h00); e.push_back(8'h00); e.push_back(8'h00); e.push_back(8'(a));
            end
        e.push_back(8'hA5);
        check_frame(0, b0, e, "s3");
        chk("s3_rden_cnt", rlog0.size() - r0, 12);
        for (int i = 0; i < 12 && r0 + i < rlog0.size(); i++) begin
            chk($sformatf("s3_addr%0d", i), alog0[r0+i], i / 4);
            chk($sformatf("s3_rden%0d", i), rlog0[r0+i], 4'b0001 << (i % 4));
        end
        chk("s3_onehot", onehot_bad0, 0);

        // Scenario: start while busy and spurious tx_done in RD_WAIT.
        mem0[0][0] = 32'h11223344;
        mem0[1][0] = 32'h55667788;
        mem0[2][0] = 32'h99AABBCC;
        mem0[3][0] = 32'hDDEEFF00;
        b0 = bytes0.size(); d0 = dones0;
        fork
            begin
                start_frame(0, 1);
                repeat (3) tick();
                start_frame(0, 3);
                wait_done(0, d0, "s4");
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    int n;
                    n = 0;
                    while (rden0 == 4'd0 && n < 2000) begin tick(); n++; end
                    tick();
                    spur0 = 1'b1;
                    tick();
                    spur0 = 1'b0;
                end
            end
        join
        e = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'hA5};
        check_frame(0, b0, e, "s4");

        // Scenario: reset after the 5th byte, then a fresh frame.
        b0 = sends0;
        start_frame(0, 1);
        begin
            int n;
            n = 0;
            while (sends0 < b0 + 5 && n < 2000) begin tick(); n++; end
        end
        rst = 1'b1;
        s5 = sends0;
        tick();
        chk("s5_send_after_rst", send0, 1'b0);
        chk("s5_busy_after_rst", busy0, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        chk("s5_no_more_sends", sends0, s5);
        b0 = bytes0.size(); d0 = dones0;
        start_frame(0, 1);
        wait_done(0, d0, "s5");
        check_frame(0, b0, e, "s5");

        // Scenario: RD_LAT=1 build, random data, 8 words.
        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 8; a++) mem1[k][a] = $urandom;
        e = {};
        e.push_back(8'hA5);
        cs = 8'hA5;
        for (int a = 0; a < 8; a++)
            for (int k = 0; k < 4; k++)
                for (int b = 3; b >= 0; b--) begin
                    logic [31:0] w;
                    w = mem1[k][a];
                    e.push_back(w[8*b +: 8]);
                    cs = cs ^ w[8*b +: 8];
                end
        e.push_back(cs);
        b0 = bytes1.size(); d0 = dones1;
        start_frame(1, 8);
        wait_done(1, d0, "s6");
        check_frame(1, b0, e, "s6");

        chk("no_overlap0", overlap0, 0);
        chk("no_overlap1", overlap1, 0);
        chk("busy_falls_with_done", busy_done_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
